// File: rtl/rv_pipe_pkg.sv
// Shared encodings for the five-stage pipeline control logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_pipe_pkg;

    // EX operand source select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    // Hazard sequencer states
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } hz_state_t;

    // Legal data-memory read latency range
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    // Worst case is an un-forwarded load: MEM_LAT_MAX + 1 bubbles
    localparam int STALL_CNT_W = 3;

endpackage

// File: rtl/rv_sat_counter.sv
// Saturating event counter: counts i_inc cycles, holds at all-ones.
// Latency: count reflects an event one cycle after it occurs.
// Backpressure: none; never stalls, never wraps.
//
// Ports: i_clk, i_reset_n (async active-low), i_inc (count this cycle),
//        o_count [CNT_W-1:0].
module rv_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_count <= '0;
        end else if (i_inc && (o_count != '1)) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/rv_hazard_unit.sv
// Hazard / forwarding / flush controller for the five-stage RISC-V pipeline.
// Latency: stall, flush and forward outputs are combinational (0 cycles); counters lag 1 cycle.
// Backpressure: holds PC and IF/ID and bubbles ID/EX for the required cycles; taken branch overrides.
//
// Ports: i_clk, i_reset_n (async active-low); ID sources/use bits; ID/EX, EX/MEM, MEM/WB
//        destinations and write/load controls; i_ex_branch_taken.  Outputs: o_pc_stall,
//        o_if_id_stall, o_id_ex_bubble, o_if_id_flush, o_fwd_a/o_fwd_b, o_stall_cycles,
//        o_flush_events.
// Build option: RV_FORWARD_EN enables EX operand forwarding (only load-use then stalls);
//        without it forwards are tied to the register file and every RAW hazard stalls.
module rv_hazard_unit
    import rv_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [RADDR_W-1:0] i_id_rs1,
    input  logic [RADDR_W-1:0] i_id_rs2,
    input  logic               i_id_rs1_used,
    input  logic               i_id_rs2_used,
    input  logic [RADDR_W-1:0] i_ex_rd,
    input  logic               i_ex_reg_write,
    input  logic               i_ex_mem_read,
    input  logic [RADDR_W-1:0] i_ex_rs1,
    input  logic [RADDR_W-1:0] i_ex_rs2,
    input  logic [RADDR_W-1:0] i_mem_rd,
    input  logic               i_mem_reg_write,
    input  logic [RADDR_W-1:0] i_wb_rd,
    input  logic               i_wb_reg_write,
    input  logic               i_ex_branch_taken,
    output logic               o_pc_stall,
    output logic               o_if_id_stall,
    output logic               o_id_ex_bubble,
    output logic               o_if_id_flush,
    output logic [1:0]         o_fwd_a,
    output logic [1:0]         o_fwd_b,
    output logic [CNT_W-1:0]   o_stall_cycles,
    output logic [CNT_W-1:0]   o_flush_events
);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
        $error("rv_hazard_unit: MEM_LAT must be within 1..4");
    end
    // Counters are read through CSR pairs, so anything wider than 2*XLEN is unreadable
    if (CNT_W < 1 || CNT_W > 2 * XLEN) begin : g_bad_cnt_w
        $error("rv_hazard_unit: CNT_W must be within 1..2*XLEN");
    end

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

    hz_state_t                state;
    logic [STALL_CNT_W-1:0]   stall_cnt;
    logic [STALL_CNT_W-1:0]   bubbles;
    logic                     ex_hit;
    logic                     stall_active;
    logic                     stall_c;
    logic                     bubble_c;
    logic                     flush_c;
    fwd_sel_t                 fwd_a;
    fwd_sel_t                 fwd_b;

    // ID reads a register the instruction in EX is about to write; x0 is never a hazard
    assign ex_hit = i_ex_reg_write && (i_ex_rd != '0) &&
                    ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                     (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));

`ifdef RV_FORWARD_EN
    localparam logic [STALL_CNT_W-1:0] LOAD_BUBBLES = STALL_CNT_W'(MEM_LAT);

    function automatic fwd_sel_t pick_src(
        input logic [RADDR_W-1:0] rs,
        input logic               mem_wr,
        input logic [RADDR_W-1:0] mem_rd,
        input logic               wb_wr,
        input logic [RADDR_W-1:0] wb_rd
    );
        // EX/MEM holds the younger value, so it wins over MEM/WB
        if (rs == '0)                        return FWD_RF;
        else if (mem_wr && (mem_rd == rs))   return FWD_MEM;
        else if (wb_wr && (wb_rd == rs))     return FWD_WB;
        else                                 return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = pick_src(i_ex_rs1, i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd);
        fwd_b = pick_src(i_ex_rs2, i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd);
    end

    // Only a load result arrives too late to forward
    always_comb begin
        bubbles = '0;
        if (ex_hit && i_ex_mem_read) bubbles = LOAD_BUBBLES;
    end
`else
    localparam logic [STALL_CNT_W-1:0] EX_ALU_BUBBLES  = STALL_CNT_W'(2);
    localparam logic [STALL_CNT_W-1:0] EX_LOAD_BUBBLES = STALL_CNT_W'(MEM_LAT + 1);

    logic mem_hit;
    logic unused_fwd_inputs;

    assign unused_fwd_inputs = ^{i_ex_rs1, i_ex_rs2, i_wb_rd, i_wb_reg_write};

    assign mem_hit = i_mem_reg_write && (i_mem_rd != '0) &&
                     ((i_id_rs1_used && (i_id_rs1 == i_mem_rd)) ||
                      (i_id_rs2_used && (i_id_rs2 == i_mem_rd)));

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
    end

    // Wait until the writer has passed WB (write-first regfile makes WB itself safe).
    // An EX writer always needs more bubbles than a MEM writer, so it takes priority.
    always_comb begin
        bubbles = '0;
        if (ex_hit)       bubbles = i_ex_mem_read ? EX_LOAD_BUBBLES : EX_ALU_BUBBLES;
        else if (mem_hit) bubbles = CNT_ONE;
    end
`endif

    assign stall_active = (state == STALL) && (stall_cnt != '0);

    // Branch squash beats any stall; otherwise stall while sequencing or on a fresh hazard
    always_comb begin
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        if (i_ex_branch_taken) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
        end else if (stall_active || (bubbles != '0)) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else if (i_ex_branch_taken) begin
            state     <= FLUSH;
            stall_cnt <= '0;
        end else if (stall_active) begin
            stall_cnt <= stall_cnt - 1'b1;
            state     <= (stall_cnt == CNT_ONE) ? RUN : STALL;
        end else if (bubbles > CNT_ONE) begin
            // This cycle is the first bubble; STALL covers the rest
            stall_cnt <= bubbles - 1'b1;
            state     <= STALL;
        end else begin
            state     <= RUN;
        end
    end

    // Reset forces every control output low at once, even with hazard inputs present
    assign o_pc_stall     = i_reset_n & stall_c;
    assign o_if_id_stall  = i_reset_n & stall_c;
    assign o_id_ex_bubble = i_reset_n & bubble_c;
    assign o_if_id_flush  = i_reset_n & flush_c;
    assign o_fwd_a        = i_reset_n ? fwd_a : FWD_RF;
    assign o_fwd_b        = i_reset_n ? fwd_b : FWD_RF;

    rv_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (o_pc_stall),
        .o_count   (o_stall_cycles)
    );

    rv_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (o_if_id_flush),
        .o_count   (o_flush_events)
    );

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Bench for rv_hazard_unit: two instances (MEM_LAT=1 with 4-bit counters, MEM_LAT=3 with 32-bit).
// Expected outputs and counter values are queued per driven cycle and compared on the falling edge.
// Expectations follow RV_FORWARD_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_rv_hazard_unit;

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_rs1_used;
        logic       id_rs2_used;
        logic [4:0] ex_rd;
        logic       ex_wr;
        logic       ex_ld;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] mem_rd;
        logic       mem_wr;
        logic [4:0] wb_rd;
        logic       wb_wr;
        logic       br;
    } hz_in_t;

    typedef struct {
        int          tag;
        bit          which;   // 0: dut_a, 1: dut_b
        hz_in_t      in;
        logic        stall;
        logic        bub;
        logic        flush;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] sc;
        logic [31:0] fc;
    } vec_t;

`ifdef RV_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // Load-use stall length on each instance
    localparam int LD_A = FWD ? 1 : 2;
    localparam int LD_B = FWD ? 3 : 4;

    logic   clk;
    logic   rst_n;
    hz_in_t in_a;
    hz_in_t in_b;

    logic       a_pc, a_ifid, a_bub, a_fl;
    logic [1:0] a_fa, a_fb;
    logic [3:0] a_sc, a_fc;
    logic       b_pc, b_ifid, b_bub, b_fl;
    logic [1:0] b_fa, b_fb;
    logic [31:0] b_sc, b_fc;

    rv_hazard_unit #(.XLEN(32), .RADDR_W(5), .MEM_LAT(1), .CNT_W(4)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_id_rs1(in_a.id_rs1), .i_id_rs2(in_a.id_rs2),
        .i_id_rs1_used(in_a.id_rs1_used), .i_id_rs2_used(in_a.id_rs2_used),
        .i_ex_rd(in_a.ex_rd), .i_ex_reg_write(in_a.ex_wr), .i_ex_mem_read(in_a.ex_ld),
        .i_ex_rs1(in_a.ex_rs1), .i_ex_rs2(in_a.ex_rs2),
        .i_mem_rd(in_a.mem_rd), .i_mem_reg_write(in_a.mem_wr),
        .i_wb_rd(in_a.wb_rd), .i_wb_reg_write(in_a.wb_wr),
        .i_ex_branch_taken(in_a.br),
        .o_pc_stall(a_pc), .o_if_id_stall(a_ifid), .o_id_ex_bubble(a_bub),
        .o_if_id_flush(a_fl), .o_fwd_a(a_fa), .o_fwd_b(a_fb),
        .o_stall_cycles(a_sc), .o_flush_events(a_fc)
    );

    rv_hazard_unit #(.XLEN(32), .RADDR_W(5), .MEM_LAT(3), .CNT_W(32)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_id_rs1(in_b.id_rs1), .i_id_rs2(in_b.id_rs2),
        .i_id_rs1_used(in_b.id_rs1_used), .i_id_rs2_used(in_b.id_rs2_used),
        .i_ex_rd(in_b.ex_rd), .i_ex_reg_write(in_b.ex_wr), .i_ex_mem_read(in_b.ex_ld),
        .i_ex_rs1(in_b.ex_rs1), .i_ex_rs2(in_b.ex_rs2),
        .i_mem_rd(in_b.mem_rd), .i_mem_reg_write(in_b.mem_wr),
        .i_wb_rd(in_b.wb_rd), .i_wb_reg_write(in_b.wb_wr),
        .i_ex_branch_taken(in_b.br),
        .o_pc_stall(b_pc), .o_if_id_stall(b_ifid), .o_id_ex_bubble(b_bub),
        .o_if_id_flush(b_fl), .o_fwd_a(b_fa), .o_fwd_b(b_fb),
        .o_stall_cycles(b_sc), .o_flush_events(b_fc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks;
    int          n_fail;
    vec_t        sb[$];
    vec_t        tbl[14];
    logic [31:0] exp_sc[2];
    logic [31:0] exp_fc[2];
    logic [31:0] cmax[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] fx(input logic [1:0] code);
        return FWD ? code : 2'b00;
    endfunction

    function automatic vec_t mkv(input int tag, input bit which, input hz_in_t in,
                                 input logic st, input logic bub, input logic fl,
                                 input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.tag = tag; v.which = which; v.in = in;
        v.stall = st; v.bub = bub; v.flush = fl;
        v.fa = fa; v.fb = fb;
        v.sc = '0; v.fc = '0;
        return v;
    endfunction

    // Drive one cycle and queue what the selected instance must show for it.
    // Counter expectations are the totals of earlier cycles (one-cycle visibility).
    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        in_a = v.which ? hz_in_t'(0) : v.in;
        in_b = v.which ? v.in : hz_in_t'(0);
        v.sc = exp_sc[v.which];
        v.fc = exp_fc[v.which];
        if (v.stall && (exp_sc[v.which] != cmax[v.which])) exp_sc[v.which] += 1;
        if (v.flush && (exp_fc[v.which] != cmax[v.which])) exp_fc[v.which] += 1;
        sb.push_back(v);
    endtask

    task automatic drain();
        for (int i = 0; i < 5 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("scoreboard_drain", sb.size(), 0);
    endtask

    vec_t cur;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            check($sformatf("v%0d.pc_stall", cur.tag),    cur.which ? b_pc   : a_pc,   cur.stall);
            check($sformatf("v%0d.if_id_stall", cur.tag), cur.which ? b_ifid : a_ifid, cur.stall);
            check($sformatf("v%0d.bubble", cur.tag),      cur.which ? b_bub  : a_bub,  cur.bub);
            check($sformatf("v%0d.flush", cur.tag),       cur.which ? b_fl   : a_fl,   cur.flush);
            check($sformatf("v%0d.fwd_a", cur.tag),       cur.which ? b_fa   : a_fa,   cur.fa);
            check($sformatf("v%0d.fwd_b", cur.tag),       cur.which ? b_fb   : a_fb,   cur.fb);
            check($sformatf("v%0d.stall_cycles", cur.tag),
                  cur.which ? b_sc : {28'h0, a_sc}, cur.sc);
            check($sformatf("v%0d.flush_events", cur.tag),
                  cur.which ? b_fc : {28'h0, a_fc}, cur.fc);
        end
    end

    task automatic check_all_zero(input string pfx);
        check({pfx, ".a_ctrl"}, {a_pc, a_ifid, a_bub, a_fl}, 0);
        check({pfx, ".a_fwd"},  {a_fa, a_fb}, 0);
        check({pfx, ".a_cnt"},  {a_sc, a_fc}, 0);
        check({pfx, ".b_ctrl"}, {b_pc, b_ifid, b_bub, b_fl}, 0);
        check({pfx, ".b_fwd"},  {b_fa, b_fb}, 0);
        check({pfx, ".b_sc"},   b_sc, 0);
        check({pfx, ".b_fc"},   b_fc, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    hz_in_t idle, load5, load5_br, alu3, mem3, t;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_sc   = '{32'h0, 32'h0};
        exp_fc   = '{32'h0, 32'h0};
        cmax     = '{32'hF, 32'hFFFF_FFFF};

        idle     = '0;
        load5    = '{id_rs1: 5'd5, id_rs1_used: 1'b1, ex_rd: 5'd5, ex_wr: 1'b1, ex_ld: 1'b1, default: '0};
        load5_br = load5;
        load5_br.br = 1'b1;
        alu3     = '{id_rs1: 5'd3, id_rs1_used: 1'b1, ex_rd: 5'd3, ex_wr: 1'b1, default: '0};
        mem3     = '{id_rs1: 5'd3, id_rs1_used: 1'b1, mem_rd: 5'd3, mem_wr: 1'b1, default: '0};

        // Single-cycle vectors on dut_a; none leaves the sequencer mid-stall
        tbl[0]  = mkv(0, 0, idle, 0, 0, 0, 2'b00, 2'b00);
        t = '{mem_rd: 5'd7, mem_wr: 1'b1, wb_rd: 5'd7, wb_wr: 1'b1, ex_rs1: 5'd7, default: '0};
        tbl[1]  = mkv(1, 0, t, 0, 0, 0, fx(2'b01), 2'b00);
        t = '{wb_rd: 5'd7, wb_wr: 1'b1, mem_rd: 5'd7, ex_rs1: 5'd7, default: '0};
        tbl[2]  = mkv(2, 0, t, 0, 0, 0, fx(2'b10), 2'b00);
        t = '{mem_rd: 5'd9, mem_wr: 1'b1, ex_rs1: 5'd9, ex_rs2: 5'd9, default: '0};
        tbl[3]  = mkv(3, 0, t, 0, 0, 0, fx(2'b01), fx(2'b01));
        t = '{wb_rd: 5'd4, wb_wr: 1'b1, mem_rd: 5'd5, mem_wr: 1'b1, ex_rs1: 5'd6, ex_rs2: 5'd4, default: '0};
        tbl[4]  = mkv(4, 0, t, 0, 0, 0, 2'b00, fx(2'b10));
        t = '{mem_wr: 1'b1, wb_wr: 1'b1, default: '0};
        tbl[5]  = mkv(5, 0, t, 0, 0, 0, 2'b00, 2'b00);
        t = '{wb_rd: 5'd3, wb_wr: 1'b1, id_rs1: 5'd3, id_rs1_used: 1'b1, ex_rs1: 5'd3, default: '0};
        tbl[6]  = mkv(6, 0, t, 0, 0, 0, fx(2'b10), 2'b00);
        t = '{ex_wr: 1'b1, ex_ld: 1'b1, id_rs1_used: 1'b1, default: '0};
        tbl[7]  = mkv(7, 0, t, 0, 0, 0, 2'b00, 2'b00);
        t = '{ex_rd: 5'd5, ex_wr: 1'b1, ex_ld: 1'b1, id_rs1: 5'd5, default: '0};
        tbl[8]  = mkv(8, 0, t, 0, 0, 0, 2'b00, 2'b00);
        t = '{ex_rd: 5'd5, ex_ld: 1'b1, id_rs2: 5'd5, id_rs2_used: 1'b1, default: '0};
        tbl[9]  = mkv(9, 0, t, 0, 0, 0, 2'b00, 2'b00);
        t = '{mem_rd: 5'd3, mem_wr: 1'b1, id_rs2: 5'd3, id_rs2_used: 1'b1, default: '0};
        tbl[10] = mkv(10, 0, t, !FWD, !FWD, 0, 2'b00, 2'b00);
        t = '{br: 1'b1, default: '0};
        tbl[11] = mkv(11, 0, t, 0, 1, 1, 2'b00, 2'b00);
        tbl[12] = mkv(12, 0, idle, 0, 0, 0, 2'b00, 2'b00);
        tbl[13] = mkv(13, 0, idle, 0, 0, 0, 2'b00, 2'b00);

        // Reset state, with a load-use hazard presented to dut_a
        rst_n = 1'b0;
        in_a  = load5;
        in_b  = idle;
        #3;
        check_all_zero("reset");
        in_a = idle;
        #4;
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // Load-use on MEM_LAT=1
        for (int i = 0; i < LD_A; i++) apply(mkv(100 + i, 0, load5, 1, 1, 0, 2'b00, 2'b00));
        apply(mkv(110, 0, idle, 0, 0, 0, 2'b00, 2'b00));
        apply(mkv(111, 0, idle, 0, 0, 0, 2'b00, 2'b00));

        // Load-use on MEM_LAT=3: consecutive stalls then release
        for (int i = 0; i < LD_B; i++) apply(mkv(200 + i, 1, load5, 1, 1, 0, 2'b00, 2'b00));
        apply(mkv(210, 1, idle, 0, 0, 0, 2'b00, 2'b00));
        apply(mkv(211, 1, idle, 0, 0, 0, 2'b00, 2'b00));

        // Taken branch during the second STALL cycle
        apply(mkv(300, 1, load5,    1, 1, 0, 2'b00, 2'b00));
        apply(mkv(301, 1, load5,    1, 1, 0, 2'b00, 2'b00));
        apply(mkv(302, 1, load5_br, 0, 1, 1, 2'b00, 2'b00));
        apply(mkv(303, 1, idle,     0, 0, 0, 2'b00, 2'b00));
        apply(mkv(304, 1, idle,     0, 0, 0, 2'b00, 2'b00));

        // ALU writer in EX then in MEM
        for (int i = 0; i < (FWD ? 1 : 2); i++) apply(mkv(400 + i, 0, alu3, !FWD, !FWD, 0, 2'b00, 2'b00));
        apply(mkv(410, 0, mem3, !FWD, !FWD, 0, 2'b00, 2'b00));
        apply(mkv(411, 0, idle, 0, 0, 0, 2'b00, 2'b00));

        // Continuous stall drives the 4-bit counter into saturation
        for (int i = 0; i < 20; i++) apply(mkv(500 + i, 0, load5, 1, 1, 0, 2'b00, 2'b00));
        apply(mkv(520, 0, idle, 0, 0, 0, 2'b00, 2'b00));
        apply(mkv(521, 0, idle, 0, 0, 0, 2'b00, 2'b00));
        drain();
        check("sat.stall_cycles_all_ones", {28'h0, a_sc}, 32'hF);

        // Reset asserted in the middle of a stall
        @(posedge clk);
        #1;
        in_a = load5;
        in_b = load5;
        #2;
        check("rst_mid.a_stalling", a_pc, 1);
        check("rst_mid.b_stalling", b_pc, 1);
        #1;
        rst_n = 1'b0;
        #2;
        check_all_zero("rst_mid");
        in_a = idle;
        in_b = idle;
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        exp_sc = '{32'h0, 32'h0};
        exp_fc = '{32'h0, 32'h0};

        // Back to normal operation after reset
        apply(mkv(600, 0, idle, 0, 0, 0, 2'b00, 2'b00));
        for (int i = 0; i < LD_A; i++) apply(mkv(601 + i, 0, load5, 1, 1, 0, 2'b00, 2'b00));
        apply(mkv(610, 0, idle, 0, 0, 0, 2'b00, 2'b00));
        apply(mkv(611, 0, idle, 0, 0, 0, 2'b00, 2'b00));
        apply(mkv(612, 1, idle, 0, 0, 0, 2'b00, 2'b00));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_hazard_unit.md
# rv_hazard_unit

Parametrised hazard, forwarding and flush controller for the five-stage RISC-V pipeline. Sits beside the IF/ID/EX/MEM/WB stage modules and takes register indices and control bits from the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Drives PC/IF-ID stall, IF-ID/ID-EX flush and EX operand forward selects. Supports a configurable data-memory latency through a stall-sequencing FSM, and keeps saturating stall/flush performance counters.

## Interface
- XLEN, 32: datapath width; used only for counter-width sanity checks.
- RADDR_W, 5: register index width.
- MEM_LAT, 1: data-memory read latency in cycles; legal range 1..4.
- CNT_W, 32: width of the performance counters.

- i_clk  in  1  clock.
- i_reset_n  in  1  reset; asynchronous assert, active-low.
- i_id_rs1, i_id_rs2  in  RADDR_W  source registers of the instruction in ID.
- i_id_rs1_used, i_id_rs2_used  in  1  the ID instruction reads rs1/rs2.
- i_ex_rd, i_ex_reg_write, i_ex_mem_read  in  RADDR_W/1/1  ID/EX destination and control.
- i_ex_rs1, i_ex_rs2  in  RADDR_W  ID/EX source registers, used for forwarding.
- i_mem_rd, i_mem_reg_write  in  RADDR_W/1  EX/MEM destination and control.
- i_wb_rd, i_wb_reg_write  in  RADDR_W/1  MEM/WB destination and control.
- i_ex_branch_taken  in  1  branch or jump resolved taken in EX.
- o_pc_stall, o_if_id_stall  out  1  hold PC and IF/ID.
- o_id_ex_bubble  out  1  load NOP control into ID/EX.
- o_if_id_flush  out  1  squash IF/ID.
- o_fwd_a, o_fwd_b  out  2  EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB data.
- o_stall_cycles, o_flush_events  out  CNT_W  saturating performance counters.

## Operation
- A register index of 0 never causes a hazard and is never forwarded.
- Forwarding (FORWARD_EN): for each EX source, if i_mem_reg_write and i_mem_rd matches, select 01. Otherwise, if i_wb_reg_write and i_wb_rd matches, select 10. Otherwise select 00. EX/MEM has priority over MEM/WB.
- Load-use hazard: i_ex_mem_read && i_ex_reg_write && i_ex_rd matches a used ID source. Requires MEM_LAT bubbles.
- The register file is write-first, so a WB writer never stalls ID.
- FSM states RUN, STALL, FLUSH.
  - RUN: a hazard asserts o_pc_stall, o_if_id_stall and o_id_ex_bubble combinationally in the same cycle. If the required bubble count is greater than 1, load stall_cnt with (bubbles−1) and go to STALL.
  - STALL: assert the stall outputs while stall_cnt is not 0, decrementing each cycle. When stall_cnt reaches 0, return to RUN and re-evaluate the hazard that cycle.
  - i_ex_branch_taken in any state: assert o_if_id_flush and o_id_ex_bubble that cycle, deassert the stall outputs, clear stall_cnt, and go to FLUSH.
  - FLUSH: one cycle with no outputs asserted except forwarding, then RUN. A hazard detected in FLUSH is handled as in RUN.
- Branch taken wins over any simultaneous or in-progress stall.
- o_stall_cycles increments on every cycle with o_pc_stall high. o_flush_events increments on every cycle with o_if_id_flush high. Both saturate at all-ones.

## Timing
- Reset: state RUN, stall_cnt 0, all stall/flush outputs 0, o_fwd_a/o_fwd_b 00, both counters 0.
- Reset asserted mid-stall aborts the stall immediately, asynchronously.
- Hazard and forward outputs are combinational from the inputs and state. Zero-cycle latency.
- Counter update is visible one cycle after the qualifying cycle.
- Load-use with MEM_LAT=1: 1 stall cycle. MEM_LAT=3: 3 consecutive stall cycles.

## Configuration
- RV_FORWARD_EN defined: forwarding as above. Only load-use stalls are generated.
- RV_FORWARD_EN undefined: o_fwd_a and o_fwd_b tie to 00. Any RAW hazard on a used ID source stalls:
  - a matching EX writer gives 2 bubbles, plus (MEM_LAT−1) if it is a load;
  - a matching MEM writer gives 1 bubble.

## Structure
- rv_pipe_pkg holds:
  - the fwd_sel_t encoding (FWD_RF=00, FWD_MEM=01, FWD_WB=10);
  - the hz_state_t enum (RUN, STALL, FLUSH);
  - the MEM_LAT legality bound.
- One sub-module, rv_sat_counter (parameter CNT_W; ports i_clk, i_reset_n, i_inc, o_count). It is instantiated twice.

## Test plan
- Load x5 in EX, ID uses rs1=x5, MEM_LAT=1 → one cycle of o_pc_stall, o_if_id_stall and o_id_ex_bubble high. o_stall_cycles=1 afterwards.
- MEM_LAT=3, same load-use → exactly 3 consecutive stall cycles. FSM goes RUN→STALL→RUN.
- With RV_FORWARD_EN: mem_rd=x7 and wb_rd=x7 both writing, ex_rs1=x7 → o_fwd_a=01. With only wb writing → 10. With ex_rs2=x0 → o_fwd_b=00.
- i_ex_branch_taken during the second STALL cycle → flush and bubble high, stalls low that cycle. Next cycle all low. o_flush_events=1.
- Without RV_FORWARD_EN: ALU writer x3 in EX, ID reads x3 → 2 stall cycles. The same writer in MEM → 1 stall cycle.
- Preload o_stall_cycles to its saturated value, then apply a further stall → it holds all-ones. Assert i_reset_n=0 mid-stall → all outputs 0 immediately.
